// File: rtl/ps2_scancode_receiver.sv
`default_nettype none
//----------------------------------------------------------------------------
// ps2_scancode_receiver: PS/2 frame receiver with E0/F0 folding and FWFT FIFO
// Revision: 1.0
//----------------------------------------------------------------------------
module ps2_scancode_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DATA,
    input  logic                          iReady,
    input  logic                          iClearOverflow,
    output logic                          oValid,
    output logic [7:0]                    oScanCode,
    output logic                          oBreak,
    output logic                          oExtended,
    output logic                          oFrameError,
    output logic                          oOverflow,
    output logic [$clog2(FIFO_DEPTH):0]   oFifoCount
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDW-1:0] c_wd_last = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  c_full    = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   clk_s, dat_s, fall;

    state_t                 state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [WDW-1:0]         wd_q, wd_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [7:0]             byte_q, byte_d;
    logic                   frame_err;

    logic                   ext_q, ext_d, brk_q, brk_d;
    logic                   push;
    logic [9:0]             push_data;

    logic [9:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [9:0]             head_q, head_d;
    logic                   ovf_q, ovf_d;
    logic                   full, pop, do_push;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_prev_q & ~clk_s;

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_DATA};
        clk_prev_d = clk_s;
    end

    // Frame FSM; the watchdog only runs while a frame is in progress.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        byte_d    = byte_q;
        done_d    = 1'b0;
        frame_err = 1'b0;
        wd_d      = (state_q == S_IDLE) ? '0 : wd_q + WDW'(1);
        if (fall) begin
            wd_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shreg_d  = {dat_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (dat_s && (^{shreg_q, par_q})) begin
                        done_d = 1'b1;
                        byte_d = shreg_q;
                    end else begin
                        frame_err = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && wd_q == c_wd_last) begin
            state_d   = S_IDLE;
            frame_err = 1'b1;
            wd_d      = '0;
        end
        err_d = frame_err;
    end

    // Prefix decoder acts one cycle after frame completion.
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        push      = 1'b0;
        push_data = {ext_q, brk_q, byte_q};
        if (err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (done_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // FWFT FIFO; head_q tracks the entry at rd_ptr_d and holds when empty.
    always_comb begin
        full     = (count_q == c_full);
        pop      = (count_q != '0) && iReady;
        do_push  = push && (!full || pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(do_push) - CW'(pop);
        head_d   = head_q;
        if (count_d != '0) begin
            if (do_push && wr_ptr_q == rd_ptr_d) head_d = push_data;
            else                                 head_d = mem_q[rd_ptr_d];
        end
        if (push && full && !pop) ovf_d = 1'b1;
        else if (iClearOverflow)  ovf_d = 1'b0;
        else                      ovf_d = ovf_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            byte_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            byte_q     <= byte_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign oValid      = (count_q != '0);
    assign oScanCode   = head_q[7:0];
    assign oBreak      = head_q[8];
    assign oExtended   = head_q[9];
    assign oFrameError = frame_err;
    assign oOverflow   = ovf_q;
    assign oFifoCount  = count_q;

endmodule
`default_nettype wire

// File: doc/ps2_scancode_receiver.md
Name: ps2_scancode_receiver

Overview:
Parametrised successor to the keyboard front end. It samples PS/2 clock/data in the system clock domain and checks full 11-bit frames (start/parity/stop) with a watchdog timeout. It folds the E0/F0 prefixes into flags on the following code and buffers decoded codes in a FIFO read through a valid/ready handshake. It sits between the PS/2 pins and the game/display control logic, replacing direct scan-code-driven position registers.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on PS2_CLK and PS2_DATA (allowed 2..4).
FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.
TIMEOUT_CYCLES, 50000, system-clock cycles without a PS2_CLK falling edge before an in-progress frame is aborted (2 ms at 25 MHz).

Ports:
Clock  input  1  system clock; all logic on rising edge.
Reset  input  1  asynchronous, active-low reset.
PS2_CLK  input  1  raw PS/2 clock pin, asynchronous.
PS2_DATA  input  1  raw PS/2 data pin, asynchronous.
iReady  input  1  consumer accepts the head entry when high together with oValid.
iClearOverflow  input  1  synchronous clear of oOverflow.
oValid  output  1  FIFO not empty.
oScanCode  output  8  head-entry code byte.
oBreak  output  1  head entry was preceded by F0.
oExtended  output  1  head entry was preceded by E0.
oFrameError  output  1  one-cycle pulse on parity, stop or timeout error.
oOverflow  output  1  sticky; set when a decoded code is dropped because the FIFO is full.
oFifoCount  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (Reset=0, asynchronous):
  - Synchronizer flops load 1. FSM goes to IDLE. FIFO is emptied. Prefix flags are cleared.
  - All outputs go to 0: oValid, oScanCode, oBreak, oExtended, oFrameError, oOverflow, oFifoCount.
  - A reset mid-frame discards the partial frame; there is no resume.
- Synchronization and edge detect:
  - Each pin passes through SYNC_STAGES flops.
  - A fall is flagged when the previous synchronized clock is 1 and the current one is 0.
  - All frame logic acts only on fall cycles.
- Frame FSM (LSB first):
  - IDLE: on fall with data=0 go to DATA, bitcnt=0. A fall with data=1 is ignored.
  - DATA: shift data into shreg[7:0]. After the 8th bit go to PARITY.
  - PARITY: store the bit. The frame is good only if ^{shreg,parity}==1 (odd parity). Go to STOP.
  - STOP: data must be 1. Good parity and good stop mark the frame complete (cycle N). Otherwise pulse oFrameError in cycle N. Return to IDLE either way.
- Watchdog:
  - The counter clears on every fall and on entry to IDLE, and increments in DATA/PARITY/STOP.
  - When it reaches TIMEOUT_CYCLES-1 the FSM goes to IDLE, pulses oFrameError, and discards the partial byte.
- Decoder (acts in cycle N+1 on a complete frame):
  - E0: set ext flag; nothing is pushed.
  - F0: set brk flag; nothing is pushed.
  - Other byte: push {ext,brk,byte}, then clear both flags.
  - Any frame error or timeout clears both flags.
  - E0 after F0 keeps brk set.
- FIFO:
  - First-word-fall-through. oScanCode/oBreak/oExtended always show the head entry; they hold their last value when empty.
  - Latency: a complete frame in cycle N gives oValid=1 from cycle N+2.
  - Pop when oValid & iReady.
  - Push while full without a pop: the entry is dropped and oOverflow is set. It stays set until iClearOverflow=1 or reset. A set and a clear in the same cycle resolve to set.
  - Push and pop in the same cycle while full: both happen, no overflow, count unchanged.
  - Push while empty: no pop that cycle (oValid=0).
  - Pointers wrap modulo FIFO_DEPTH.
  - oFifoCount updates +1 on push, -1 on pop, 0 on push+pop.

Test Plan:
- Make code 0x1C (parity 0, stop 1), iReady=1 → one entry {ext=0,brk=0,code=1C}; oValid high exactly 2 cycles after the stop-bit fall is detected; oFrameError stays 0.
- Sequence E0,F0,75 → single entry {ext=1,brk=1,75}; oFifoCount peaks at 1; the next plain 0x1C gives {0,0,1C}.
- Frame 0x1C with parity=1 (wrong) → oFrameError 1-cycle pulse, no push. Separately, stop bit=0 → same result.
- 5 data bits then PS2_CLK held high for TIMEOUT_CYCLES → oFrameError pulse, FSM in IDLE. A following good 0x29 frame decodes correctly as {0,0,29}.
- iReady=0, FIFO_DEPTH=8, nine codes 0x01..0x09 → oFifoCount=8, oOverflow=1, 0x09 lost. Draining gives 01..08 in order. iClearOverflow then clears oOverflow.
- Reset asserted after 4 bits of a frame → all outputs 0 immediately (asynchronous). After release, a full 0x1C frame decodes normally.
